// File: rtl/textbuf_uart_dump_pkg.sv
// Shared constants, FSM state type and printable-character map for the
// text-buffer-to-UART dumper.
package textbuf_uart_dump_pkg;

   localparam logic [7:0] ASCII_SP    = 8'h20;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SCAN_RD,
      ST_SCAN_CHK,
      ST_FETCH,
      ST_FETCH_WT,
      ST_SEND,
      ST_CR,
      ST_LF,
      ST_DONE
   } state_e;

   // Anything outside the printable ASCII range goes out as '.'.
   function automatic logic [7:0] printable_map(input logic [7:0] b);
      return ((b >= ASCII_SP) && (b <= ASCII_TILDE)) ? b : ASCII_DOT;
   endfunction

endpackage

// File: rtl/textbuf_uart_dump_if.sv
// Text-buffer read port plus UART byte stream, seen from the dumper (master)
// and from the buffer/UART side (slave).
interface textbuf_uart_dump_if #(
   parameter int ROW_W = 6,
   parameter int COL_W = 8
);
   logic                   rd_en;
   logic [ROW_W+COL_W-1:0] rd_addr;
   logic [7:0]             rd_data;
   logic [7:0]             tx_data;
   logic                   tx_valid;
   logic                   tx_ready;

   modport master (
      output rd_en, rd_addr, tx_data, tx_valid,
      input  rd_data, tx_ready
   );

   modport slave (
      input  rd_en, rd_addr, tx_data, tx_valid,
      output rd_data, tx_ready
   );
endinterface

// File: rtl/textbuf_uart_dump.sv
// Streams the text buffer row by row to the UART: trailing spaces trimmed,
// non-printables shown as '.', each row terminated with CR LF.
module textbuf_uart_dump
   import textbuf_uart_dump_pkg::*;
#(
   parameter int COL_W = 8,
   parameter int ROW_W = 6,
   parameter int COLS  = 160,
   parameter int ROWS  = 64
) (
   input  logic                clk48,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   textbuf_uart_dump_if.master bus
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   state_e                 state_q;
   logic [ROW_W-1:0]       row_q;
   logic [COL_W-1:0]       col_q;
   logic [COL_W-1:0]       last_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   rd_en_q;
   logic [ROW_W+COL_W-1:0] rd_addr_q;
   logic [7:0]             tx_data_q;
   logic                   tx_valid_q;
   logic                   xfer;

   assign xfer         = tx_valid_q & bus.tx_ready;
   assign busy         = busy_q;
   assign done         = done_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;

   // Read strobes are issued on the transition into SCAN_RD/FETCH so that
   // rd_en is a registered output that is high exactly in those states.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         last_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  row_q     <= '0;
                  col_q     <= COL_LAST;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {ROW_W'(0), COL_LAST};
                  state_q   <= ST_SCAN_RD;
               end
            end
            ST_SCAN_RD: state_q <= ST_SCAN_CHK;
            ST_SCAN_CHK: begin
               if (bus.rd_data != ASCII_SP) begin
                  last_q    <= col_q;
                  col_q     <= '0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {row_q, COL_W'(0)};
                  state_q   <= ST_FETCH;
               end else if (col_q == '0) begin
                  tx_data_q  <= ASCII_CR;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_CR;
               end else begin
                  col_q     <= col_q - COL_W'(1);
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {row_q, col_q - COL_W'(1)};
                  state_q   <= ST_SCAN_RD;
               end
            end
            ST_FETCH: state_q <= ST_FETCH_WT;
            ST_FETCH_WT: begin
               tx_data_q  <= printable_map(bus.rd_data);
               tx_valid_q <= 1'b1;
               state_q    <= ST_SEND;
            end
            ST_SEND: begin
               if (xfer) begin
                  if (col_q == last_q) begin
                     tx_data_q <= ASCII_CR;
                     state_q   <= ST_CR;
                  end else begin
                     tx_valid_q <= 1'b0;
                     col_q      <= col_q + COL_W'(1);
                     rd_en_q    <= 1'b1;
                     rd_addr_q  <= {row_q, col_q + COL_W'(1)};
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_CR: begin
               if (xfer) begin
                  tx_data_q <= ASCII_LF;
                  state_q   <= ST_LF;
               end
            end
            ST_LF: begin
               if (xfer) begin
                  tx_valid_q <= 1'b0;
                  if (row_q == ROW_LAST) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     row_q     <= row_q + ROW_W'(1);
                     col_q     <= COL_LAST;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= {row_q + ROW_W'(1), COL_LAST};
                     state_q   <= ST_SCAN_RD;
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_textbuf_uart_dump.sv
// Directed and randomized checks of textbuf_uart_dump on a 2x4 text buffer
// against a row-trim/map/CRLF reference model.
module tb_textbuf_uart_dump;

   localparam int COL_W = 2;
   localparam int ROW_W = 1;
   localparam int COLS  = 4;
   localparam int ROWS  = 2;

   logic clk48 = 1'b0;
   logic rst_n;
   logic start;
   logic busy;
   logic done;

   textbuf_uart_dump_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   textbuf_uart_dump #(
      .COL_W(COL_W), .ROW_W(ROW_W), .COLS(COLS), .ROWS(ROWS)
   ) dut (
      .clk48 (clk48),
      .rst_n (rst_n),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk48 = ~clk48;

   logic [7:0] mem [0:ROWS*COLS-1];
   always @(posedge clk48) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   // 0: hold ready low, 1: hold high, 2: random each cycle
   int ready_mode = 1;
   always @(posedge clk48) begin
      #1;
      case (ready_mode)
         0:       bus.tx_ready = 1'b0;
         1:       bus.tx_ready = 1'b1;
         default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   int done_cnt = 0;
   always @(negedge clk48) begin
      if (rst_n && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (done) done_cnt++;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: per row, keep up to the last non-space, map, then CR LF.
   function automatic void build_exp();
      exp_q.delete();
      for (int r = 0; r < ROWS; r++) begin
         int last = -1;
         for (int c = 0; c < COLS; c++) if (mem[r*COLS+c] != 8'h20) last = c;
         for (int c = 0; c <= last; c++) begin
            logic [7:0] b = mem[r*COLS+c];
            exp_q.push_back((b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E);
         end
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endfunction

   task automatic set_row(input int r, input logic [31:0] chars);
      for (int c = 0; c < COLS; c++) mem[r*COLS+c] = chars[31-8*c -: 8];
   endtask

   task automatic pulse_start();
      @(posedge clk48); #1 start = 1'b1;
      @(posedge clk48); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (k < 2000) begin
         @(negedge clk48);
         if (done) break;
         k++;
      end
      check({tag, " done_timeout"}, 32'(k < 2000), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (k < 200) begin
         @(negedge clk48);
         if (bus.tx_valid) break;
         k++;
      end
      check({tag, " valid_timeout"}, 32'(k < 200), 32'd1);
   endtask

   task automatic check_stream(input string tag);
      check({tag, " len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      $display("stream %s: %0d bytes", tag, got_q.size());
   endtask

   task automatic run_dump(input string tag);
      build_exp();
      got_q.delete();
      done_cnt = 0;
      pulse_start();
      wait_done(tag);
      repeat (3) @(negedge clk48);
      check_stream(tag);
      check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < ROWS*COLS; i++) mem[i] = 8'h20;
      repeat (3) @(posedge clk48);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst rd_en", 32'(bus.rd_en), 32'd0);
      check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst tx_data", 32'(bus.tx_data), 32'd0);
      check("rst rd_addr", 32'(bus.rd_addr), 32'd0);
      @(negedge clk48) rst_n = 1'b1;
      repeat (2) @(negedge clk48);
      check("idle busy", 32'(busy), 32'd0);

      // 1: all spaces
      ready_mode = 1;
      run_dump("t1_blank");

      // 2: trailing and leading spaces
      set_row(0, "HI  ");
      set_row(1, "   Z");
      run_dump("t2_trim");

      // 3: stall with ready low while the first byte is offered
      set_row(0, "ABCD");
      set_row(1, "    ");
      build_exp();
      got_q.delete();
      done_cnt = 0;
      ready_mode = 0;
      pulse_start();
      wait_valid("t3");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3 stall_valid%0d", i), 32'(bus.tx_valid), 32'd1);
         check($sformatf("t3 stall_data%0d", i), 32'(bus.tx_data), 32'h41);
         @(negedge clk48);
      end
      ready_mode = 1;
      wait_done("t3");
      repeat (3) @(negedge clk48);
      check_stream("t3_stall");
      check("t3 done_cnt", 32'(done_cnt), 32'd1);

      // 4: non-printables
      set_row(0, 32'h0741FF20);
      set_row(1, "a~ !");
      run_dump("t4_map");

      // 5: start ignored mid-dump; start right after done accepted
      set_row(0, "xy z");
      set_row(1, "Q   ");
      build_exp();
      got_q.delete();
      done_cnt = 0;
      pulse_start();
      repeat (6) @(negedge clk48);
      check("t5 busy_mid", 32'(busy), 32'd1);
      pulse_start();
      wait_done("t5a");
      check_stream("t5a");
      got_q.delete();
      pulse_start();
      wait_done("t5b");
      repeat (30) @(negedge clk48);
      check_stream("t5b");
      check("t5 done_cnt", 32'(done_cnt), 32'd2);
      check("t5 busy_after", 32'(busy), 32'd0);

      // random contents with random ready
      ready_mode = 2;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < ROWS*COLS; i++)
            mem[i] = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'($urandom_range(0, 255));
         run_dump($sformatf("rnd%0d", t));
      end

      // 6: asynchronous reset during SEND
      ready_mode = 0;
      set_row(0, "ABCD");
      set_row(1, "EF  ");
      got_q.delete();
      pulse_start();
      wait_valid("t6");
      rst_n = 1'b0;
      #1;
      check("t6 tx_valid_rst", 32'(bus.tx_valid), 32'd0);
      check("t6 busy_rst", 32'(busy), 32'd0);
      check("t6 rd_en_rst", 32'(bus.rd_en), 32'd0);
      @(negedge clk48) rst_n = 1'b1;
      ready_mode = 1;
      got_q.delete();
      done_cnt = 0;
      repeat (20) @(negedge clk48);
      check("t6 no_bytes", 32'(got_q.size()), 32'd0);
      check("t6 no_done", 32'(done_cnt), 32'd0);
      check("t6 busy_idle", 32'(busy), 32'd0);
      run_dump("t6_redump");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
